// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath and its control unit.
package mips_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ALU_LOAD = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_INC  = 3'd4,
      ALU_NEG  = 3'd5,
      ALU_XOR  = 3'd6,
      ALU_COMP = 3'd7
   } alu_op_t;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_HOLD   = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port; register 0 is hard-wired to zero.
module mips_regfile
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata_a,
   output logic [WIDTH-1:0]      rdata_b
);

   logic [WIDTH-1:0] rf_q [NUM_REGS];
   logic [WIDTH-1:0] rf_d [NUM_REGS];

   // Next register contents: a single write per cycle, writes to r0 dropped.
   always_comb begin
      rf_d = rf_q;
      if (we && (waddr != '0)) begin
         rf_d[waddr] = wdata;
      end
   end

   // Register storage, cleared immediately on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : rf_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : rf_q[raddr_b];

endmodule

// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: holds PC, IR, A, B, ALUOut, MDR and the register
// file, and is steered cycle by cycle by the control unit's control word.
module mips_datapath
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             IRWrite,
   input  logic             AWrite,
   input  logic             BWrite,
   input  logic             AluOutWrite,
   input  logic             MDRWrite,
   input  logic             RegWrite,
   input  logic             IorD,
   input  logic             MemReadWrite,
   input  logic             MemtoReg,
   input  logic             AluSrcA,
   input  logic             RegDst,
   input  logic [1:0]       PCSource,
   input  logic [1:0]       AluSrcB,
   input  logic [2:0]       ALUOp,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_write,
   output logic [5:0]       opcode,
   output logic [5:0]       funct,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] alu_out_reg,
   output logic             zero,
   output logic             overflow,
   output logic             negative,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;

   logic [WIDTH-1:0]      src_a, src_b, imm_ext, alu_res;
   logic [WIDTH-1:0]      rf_rdata_a, rf_rdata_b, reg_wdata;
   logic [REG_ADDR_W-1:0] reg_waddr;
   alu_op_t               alu_op;

   assign alu_op    = alu_op_t'(ALUOp);
   assign reg_waddr = (RegDst == 1'b1) ? ir_q[15:11] : ir_q[20:16];
   assign reg_wdata = (MemtoReg == 1'b1) ? mdr_q : alu_out_q;

   mips_regfile #(
      .WIDTH(WIDTH)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .raddr_a (ir_q[25:21]),
      .raddr_b (ir_q[20:16]),
      .we      (RegWrite == 1'b1),
      .waddr   (reg_waddr),
      .wdata   (reg_wdata),
      .rdata_a (rf_rdata_a),
      .rdata_b (rf_rdata_b)
   );

   // ALU operand selection, including the sign-extended immediate forms.
   always_comb begin
      imm_ext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
      src_a   = (AluSrcA == 1'b1) ? a_q : pc_q;
      case (AluSrcB)
         SRCB_REG:  src_b = b_q;
         SRCB_FOUR: src_b = WIDTH'(4);
         SRCB_IMM:  src_b = imm_ext;
         default:   src_b = imm_ext << 2;
      endcase
   end

   // ALU result and signed overflow; overflow only means something for add/sub/inc.
   always_comb begin
      alu_res  = src_a;
      overflow = 1'b0;
      case (alu_op)
         ALU_LOAD: alu_res = src_a;
         ALU_ADD: begin
            alu_res  = src_a + src_b;
            overflow = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
         end
         ALU_SUB: begin
            alu_res  = src_a - src_b;
            overflow = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
         end
         ALU_AND:  alu_res = src_a & src_b;
         ALU_INC: begin
            alu_res  = src_a + WIDTH'(1);
            overflow = !src_a[MSB] && alu_res[MSB];
         end
         ALU_NEG:  alu_res = ~src_a;
         ALU_XOR:  alu_res = src_a ^ src_b;
         ALU_COMP: alu_res = src_a;
         default:  alu_res = src_a;
      endcase
   end

   assign zero     = (alu_res == '0);
   assign negative = alu_res[MSB];
   assign eq       = (src_a == src_b);
   assign gt       = ($signed(src_a) > $signed(src_b));
   assign lt       = ($signed(src_a) < $signed(src_b));

   // Next-state values for the architectural registers; a register holds unless its enable is 1.
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      if (PCWrite == 1'b1) begin
         case (PCSource)
            PCSRC_ALU:    pc_d = alu_res;
            PCSRC_ALUOUT: pc_d = alu_out_q;
            PCSRC_JUMP:   pc_d = {pc_q[MSB:MSB-3], ir_q[25:0], 2'b00};
            default:      pc_d = pc_q;
         endcase
      end
      if (IRWrite == 1'b1)     ir_d      = mem_rdata;
      if (AWrite == 1'b1)      a_d       = rf_rdata_a;
      if (BWrite == 1'b1)      b_d       = rf_rdata_b;
      if (AluOutWrite == 1'b1) alu_out_d = alu_res;
      if (MDRWrite == 1'b1)    mdr_d     = mem_rdata;
   end

   // Architectural register bank, cleared immediately on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
      end
   end

   assign mem_addr    = (IorD == 1'b1) ? alu_out_q : pc_q;
   assign mem_wdata   = b_q;
   assign mem_write   = MemReadWrite;
   assign opcode      = ir_q[31:26];
   assign funct       = ir_q[5:0];
   assign pc_out      = pc_q;
   assign alu_result  = alu_res;
   assign alu_out_reg = alu_out_q;

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: directed scenarios followed by random
// control words, all compared against a behavioural model of the datapath.
module tb_mips_datapath;

   logic        clock = 1'b0;
   logic        reset;
   logic        PCWrite, IRWrite, AWrite, BWrite, AluOutWrite, MDRWrite, RegWrite;
   logic        IorD, MemReadWrite, MemtoReg, AluSrcA, RegDst;
   logic [1:0]  PCSource, AluSrcB;
   logic [2:0]  ALUOp;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr, mem_wdata, pc_out, alu_result, alu_out_reg;
   logic        mem_write, zero, overflow, negative, eq, gt, lt;
   logic [5:0]  opcode, funct;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc, m_ir, m_a, m_b, m_aluout, m_mdr;
   logic [31:0] m_rf [32];

   localparam longint MAX_S = 64'sh7FFFFFFF;
   localparam longint MIN_S = -64'sh80000000;

   always #5 clock = ~clock;

   mips_datapath dut (
      .clock        (clock),
      .reset        (reset),
      .PCWrite      (PCWrite),
      .IRWrite      (IRWrite),
      .AWrite       (AWrite),
      .BWrite       (BWrite),
      .AluOutWrite  (AluOutWrite),
      .MDRWrite     (MDRWrite),
      .RegWrite     (RegWrite),
      .IorD         (IorD),
      .MemReadWrite (MemReadWrite),
      .MemtoReg     (MemtoReg),
      .AluSrcA      (AluSrcA),
      .RegDst       (RegDst),
      .PCSource     (PCSource),
      .AluSrcB      (AluSrcB),
      .ALUOp        (ALUOp),
      .mem_rdata    (mem_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_write    (mem_write),
      .opcode       (opcode),
      .funct        (funct),
      .pc_out       (pc_out),
      .alu_result   (alu_result),
      .alu_out_reg  (alu_out_reg),
      .zero         (zero),
      .overflow     (overflow),
      .negative     (negative),
      .eq           (eq),
      .gt           (gt),
      .lt           (lt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic void model_reset();
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_aluout = 0; m_mdr = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      return (idx == 0) ? 32'd0 : m_rf[idx];
   endfunction

   // Reference ALU written with wide signed arithmetic.
   function automatic void model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic ovf);
      longint sa, sb, wide;
      sa  = $signed(a);
      sb  = $signed(b);
      ovf = 1'b0;
      res = a;
      case (op)
         3'd1: begin wide = sa + sb; res = wide[31:0]; ovf = (wide > MAX_S) || (wide < MIN_S); end
         3'd2: begin wide = sa - sb; res = wide[31:0]; ovf = (wide > MAX_S) || (wide < MIN_S); end
         3'd3: res = a & b;
         3'd4: begin wide = sa + 1; res = wide[31:0]; ovf = (wide > MAX_S); end
         3'd5: res = ~a;
         3'd6: res = a ^ b;
         default: res = a;
      endcase
   endfunction

   // One clock cycle: check combinational outputs against the model, then advance the model at the edge.
   task automatic applyStimulus(input string tag);
      logic [31:0] sa_v, sb_v, imm, res, pc_n, wdata_n, a_n, b_n;
      logic [4:0]  waddr_n;
      logic        ovf;
      longint      ia, ib;
      #1;
      imm  = {{16{m_ir[15]}}, m_ir[15:0]};
      sa_v = AluSrcA ? m_a : m_pc;
      case (AluSrcB)
         2'd0: sb_v = m_b;
         2'd1: sb_v = 32'd4;
         2'd2: sb_v = imm;
         default: sb_v = imm * 4;
      endcase
      model_alu(ALUOp, sa_v, sb_v, res, ovf);
      ia = $signed(sa_v);
      ib = $signed(sb_v);
      checkOutput({tag, ":mem_addr"}, mem_addr, IorD ? m_aluout : m_pc);
      checkOutput({tag, ":mem_wdata"}, mem_wdata, m_b);
      checkOutput({tag, ":mem_write"}, {31'd0, mem_write}, {31'd0, MemReadWrite});
      checkOutput({tag, ":op_funct"}, {20'd0, opcode, funct}, {20'd0, m_ir[31:26], m_ir[5:0]});
      checkOutput({tag, ":pc_out"}, pc_out, m_pc);
      checkOutput({tag, ":alu_result"}, alu_result, res);
      checkOutput({tag, ":alu_out_reg"}, alu_out_reg, m_aluout);
      checkOutput({tag, ":flags"}, {26'd0, zero, overflow, negative, eq, gt, lt},
                  {26'd0, res == 0, ovf, res[31], ia == ib, ia > ib, ia < ib});
      case (PCSource)
         2'd0: pc_n = res;
         2'd1: pc_n = m_aluout;
         2'd2: pc_n = {m_pc[31:28], m_ir[25:0], 2'b00};
         default: pc_n = m_pc;
      endcase
      a_n     = model_read(m_ir[25:21]);
      b_n     = model_read(m_ir[20:16]);
      waddr_n = RegDst ? m_ir[15:11] : m_ir[20:16];
      wdata_n = MemtoReg ? m_mdr : m_aluout;
      @(posedge clock);
      if (PCWrite)     m_pc     = pc_n;
      if (AWrite)      m_a      = a_n;
      if (BWrite)      m_b      = b_n;
      if (AluOutWrite) m_aluout = res;
      if (IRWrite)     m_ir     = mem_rdata;
      if (MDRWrite)    m_mdr    = mem_rdata;
      if (RegWrite && waddr_n != 0) m_rf[waddr_n] = wdata_n;
      @(negedge clock);
   endtask

   task automatic idle();
      PCWrite = 0; IRWrite = 0; AWrite = 0; BWrite = 0; AluOutWrite = 0; MDRWrite = 0; RegWrite = 0;
      IorD = 0; MemReadWrite = 0; MemtoReg = 0; AluSrcA = 0; RegDst = 0;
      PCSource = 2'd0; AluSrcB = 2'd0; ALUOp = 3'd0; mem_rdata = 32'd0;
   endtask

   task automatic load_ir(input logic [31:0] val);
      idle(); IRWrite = 1; mem_rdata = val; applyStimulus("load_ir"); idle();
   endtask

   // Writes a full 32-bit value into register r through IR (rt field) and MDR.
   task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
      load_ir({11'd0, r, 16'd0});
      MDRWrite = 1; mem_rdata = val; applyStimulus("load_mdr"); idle();
      RegWrite = 1; MemtoReg = 1; applyStimulus("reg_write"); idle();
   endtask

   task automatic read_ab();
      idle(); AWrite = 1; BWrite = 1; applyStimulus("read_ab"); idle();
   endtask

   task automatic peek_a(input string tag, input logic [31:0] expected);
      idle(); AluSrcA = 1; ALUOp = 3'd0;
      #1 checkOutput(tag, alu_result, expected);
      applyStimulus(tag); idle();
   endtask

   initial begin
      idle();
      reset = 1;
      model_reset();
      #1;
      checkOutput("reset_pc", pc_out, 32'd0);
      checkOutput("reset_opcode", {26'd0, opcode}, 32'd0);
      checkOutput("reset_mem_addr", mem_addr, 32'd0);
      @(negedge clock);
      reset = 0;

      // PC <- PC + 4
      PCWrite = 1; ALUOp = 3'd1; AluSrcB = 2'd1;
      applyStimulus("pc_inc");
      checkOutput("pc_plus4", pc_out, 32'd4);

      // Asynchronous reset in the middle of a PC update
      PCWrite = 1; ALUOp = 3'd1; AluSrcB = 2'd1;
      #2 reset = 1;
      #1;
      model_reset();
      checkOutput("midreset_pc", pc_out, 32'd0);
      checkOutput("midreset_aluout", alu_out_reg, 32'd0);
      checkOutput("midreset_wdata", mem_wdata, 32'd0);
      @(negedge clock);
      reset = 0;
      applyStimulus("pc_inc2");
      checkOutput("pc_plus4_again", pc_out, 32'd4);
      idle();

      // Fetch then jump
      load_ir(32'h0800_0010);
      checkOutput("fetch_opcode", {26'd0, opcode}, 32'h2);
      PCWrite = 1; PCSource = 2'd2;
      applyStimulus("jump");
      checkOutput("jump_pc", pc_out, 32'h0000_0040);
      idle();

      // R-type add r3 = r1 + r2
      load_reg(5'd1, 32'd5);
      load_reg(5'd2, 32'd7);
      load_ir(32'h0022_1820);
      read_ab();
      AluSrcA = 1; AluSrcB = 2'd0; ALUOp = 3'd1; AluOutWrite = 1;
      applyStimulus("add_exec");
      checkOutput("add_aluout", alu_out_reg, 32'd12);
      idle(); RegDst = 1; RegWrite = 1;
      applyStimulus("add_wb");
      load_ir(32'h0060_0000);
      idle(); AWrite = 1; applyStimulus("read_r3");
      peek_a("rf3_value", 32'd12);

      // Store-word address with negative offset
      load_reg(5'd1, 32'h100);
      load_ir(32'hAC22_FFFC);
      read_ab();
      AluSrcA = 1; AluSrcB = 2'd2; ALUOp = 3'd1; AluOutWrite = 1;
      applyStimulus("sw_addr");
      checkOutput("sw_aluout", alu_out_reg, 32'h0000_00FC);
      idle(); IorD = 1; MemReadWrite = 1;
      #1;
      checkOutput("sw_mem_addr", mem_addr, 32'h0000_00FC);
      checkOutput("sw_mem_wdata", mem_wdata, 32'd7);
      checkOutput("sw_mem_write", {31'd0, mem_write}, 32'd1);
      applyStimulus("sw_mem");
      idle();

      // ALU corner cases
      load_reg(5'd4, 32'h7FFF_FFFF);
      load_reg(5'd5, 32'd1);
      load_ir(32'h0085_0000);
      read_ab();
      AluSrcA = 1; ALUOp = 3'd1;
      #1 checkOutput("add_ovf_flags", {30'd0, overflow, negative}, 32'd3);
      applyStimulus("add_ovf");
      load_ir(32'h0084_0000);
      read_ab();
      AluSrcA = 1; ALUOp = 3'd2;
      #1 checkOutput("sub_eq_flags", {30'd0, zero, eq}, 32'd3);
      applyStimulus("sub_eq");
      load_reg(5'd6, 32'hFFFF_FFFF);
      load_ir(32'h00C5_0000);
      read_ab();
      AluSrcA = 1; ALUOp = 3'd7;
      #1 checkOutput("comp_lt", {31'd0, lt}, 32'd1);
      applyStimulus("comp");
      idle();

      // r0 stays zero
      load_reg(5'd0, 32'h0000_DEAD);
      load_ir(32'h0000_0000);
      idle(); AWrite = 1; applyStimulus("read_r0");
      peek_a("r0_reads_zero", 32'd0);

      // Same-cycle write and read of r5
      load_ir(32'h00A5_0000);
      MDRWrite = 1; mem_rdata = 32'h0000_BEEF; applyStimulus("mdr_beef"); idle();
      RegWrite = 1; MemtoReg = 1; AWrite = 1;
      applyStimulus("wr_rd_r5");
      peek_a("r5_old_value", 32'd1);
      idle(); AWrite = 1; applyStimulus("reread_r5");
      peek_a("r5_new_value", 32'h0000_BEEF);

      // Random control words
      for (int i = 0; i < 400; i++) begin
         {PCWrite, IRWrite, AWrite, BWrite, AluOutWrite, MDRWrite, RegWrite} = 7'($urandom);
         {IorD, MemReadWrite, MemtoReg, AluSrcA, RegDst} = 5'($urandom);
         PCSource  = 2'($urandom);
         AluSrcB   = 2'($urandom);
         ALUOp     = 3'($urandom);
         mem_rdata = $urandom;
         applyStimulus("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
